// File: rtl/collide_pkg.sv
// Shared types for the sphere-collision contact path: float width and contact record layout.
package collide_pkg;

    localparam int unsigned FLOAT_W       = 32;
    localparam int unsigned CONTACT_WORDS = 7;
    localparam int unsigned PAIR_ID_W     = 8;
    localparam int unsigned CONTACT_W     = FLOAT_W * CONTACT_WORDS;

    // Field order fixes the packed layout: cx lands in the MSBs, depth in the LSBs.
    typedef struct packed {
        logic [FLOAT_W-1:0] cx;
        logic [FLOAT_W-1:0] cy;
        logic [FLOAT_W-1:0] cz;
        logic [FLOAT_W-1:0] nx;
        logic [FLOAT_W-1:0] ny;
        logic [FLOAT_W-1:0] nz;
        logic [FLOAT_W-1:0] depth;
    } contact_t;

    typedef struct packed {
        logic [PAIR_ID_W-1:0] id;
        contact_t             contact;
    } tagged_contact_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous-reset FIFO with registered storage; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; contents are only observed behind a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/contact_collector.sv
// Captures one contact record per completed collider run on a hit and queues it for readback.
// Optional statistics counters are built when CONTACT_STATS_EN is defined.
module contact_collector
    import collide_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ID_W  = 8,
    parameter int unsigned DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   done,
    input  logic [DW-1:0]          ret,
    input  logic [ID_W-1:0]        pair_id,
    input  logic [DW-1:0]          cx,
    input  logic [DW-1:0]          cy,
    input  logic [DW-1:0]          cz,
    input  logic [DW-1:0]          normalx,
    input  logic [DW-1:0]          normaly,
    input  logic [DW-1:0]          normalz,
    input  logic [DW-1:0]          depth,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7*DW-1:0]        out_contact,
    output logic [ID_W-1:0]        out_id,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
`ifdef CONTACT_STATS_EN
    output logic [31:0]            tested_cnt,
    output logic [31:0]            hit_cnt,
    output logic [15:0]            drop_cnt,
`endif
    output logic                   overflow
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        contact_t        contact;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    logic   done_q;
    logic   overflow_q, overflow_d;
    logic   evt, hit, pop, drop;
    logic   fifo_empty, fifo_full;
    entry_t wr_entry, rd_entry;

    assign evt  = done && !done_q;
    assign hit  = evt && (ret != '0);
    assign pop  = out_valid && out_ready;
    // A full FIFO still takes a hit when the head leaves on the same edge.
    assign drop = hit && fifo_full && !pop;

    always_comb begin
        wr_entry               = '0;
        wr_entry.id            = pair_id;
        wr_entry.contact.cx    = cx;
        wr_entry.contact.cy    = cy;
        wr_entry.contact.cz    = cz;
        wr_entry.contact.nx    = normalx;
        wr_entry.contact.ny    = normaly;
        wr_entry.contact.nz    = normalz;
        wr_entry.contact.depth = depth;
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= done;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hit),
        .wdata (wr_entry),
        .pop   (out_ready),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign out_valid   = !fifo_empty;
    assign out_contact = rd_entry.contact;
    assign out_id      = rd_entry.id;
    assign full        = fifo_full;
    assign overflow    = overflow_q;

`ifdef CONTACT_STATS_EN
    logic [31:0] tested_q, hit_q;
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tested_q <= '0;
            hit_q    <= '0;
            drop_q   <= '0;
        end else begin
            if (evt)  tested_q <= tested_q + 32'd1;
            if (hit)  hit_q    <= hit_q + 32'd1;
            if (drop) drop_q   <= drop_q + 16'd1;
        end
    end

    assign tested_cnt = tested_q;
    assign hit_cnt    = hit_q;
    assign drop_cnt   = drop_q;
`endif

endmodule

// File: tb/tb_contact_collector.sv
// Directed self-checking bench for contact_collector; stats checks build with CONTACT_STATS_EN.
module tb_contact_collector;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned ID_W  = 8;
    localparam int unsigned DW    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            done;
    logic [DW-1:0]   ret;
    logic [ID_W-1:0] pair_id;
    logic [DW-1:0]   cx, cy, cz, normalx, normaly, normalz, depth;
    logic            out_valid;
    logic            out_ready;
    logic [7*DW-1:0] out_contact;
    logic [ID_W-1:0] out_id;
    logic [3:0]      count;
    logic            full;
    logic            overflow;
`ifdef CONTACT_STATS_EN
    logic [31:0]     tested_cnt, hit_cnt;
    logic [15:0]     drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    contact_collector #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W),
        .DW    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .ret         (ret),
        .pair_id     (pair_id),
        .cx          (cx),
        .cy          (cy),
        .cz          (cz),
        .normalx     (normalx),
        .normaly     (normaly),
        .normalz     (normalz),
        .depth       (depth),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_contact (out_contact),
        .out_id      (out_id),
        .count       (count),
        .full        (full),
`ifdef CONTACT_STATS_EN
        .tested_cnt  (tested_cnt),
        .hit_cnt     (hit_cnt),
        .drop_cnt    (drop_cnt),
`endif
        .overflow    (overflow)
    );

    function automatic logic [31:0] word(input logic [7:0] id, input int k);
        logic [3:0] kk;
        kk = 4'(k);
        return {4'hA, kk, 16'h0000, id};
    endfunction

    function automatic logic [223:0] exp_contact(input logic [7:0] id, input logic [31:0] dep);
        return {word(id, 0), word(id, 1), word(id, 2), word(id, 3), word(id, 4), word(id, 5),
                dep};
    endfunction

    // Drives one collider run; returns at the negedge right after the capture edge.
    task automatic hit(input logic [7:0] id, input logic [31:0] r, input logic [31:0] dep);
        @(negedge clk);
        done    = 1'b1;
        ret     = r;
        pair_id = id;
        cx      = word(id, 0);
        cy      = word(id, 1);
        cz      = word(id, 2);
        normalx = word(id, 3);
        normaly = word(id, 4);
        normalz = word(id, 5);
        depth   = dep;
        @(negedge clk);
        done    = 1'b0;
        ret     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        done      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_id !== 8'(start + i) ||
                out_contact !== exp_contact(8'(start + i), word(8'(start + i), 6))) begin
                fails++;
                $display("FAIL drain[%0d]: valid=%b id=%0d contact=%h, want valid=1 id=%0d",
                         i, out_valid, out_id, out_contact, start + i);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        tests++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL drain_empty: valid=%b count=%0d, want 0/0", out_valid, count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || count !== 4'd0 || full !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset: valid=%b count=%0d full=%b ovf=%b, want all 0",
                     out_valid, count, full, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_hit();
        do_reset();
        hit(8'd3, 32'd1, 32'h3C6F0000);
        tests++;
        if (out_valid !== 1'b1 || out_id !== 8'd3 || out_contact[31:0] !== 32'h3C6F0000 ||
            count !== 4'd1) begin
            fails++;
            $display("FAIL hit: valid=%b id=%0d depth=%h count=%0d, want 1/3/3c6f0000/1",
                     out_valid, out_id, out_contact[31:0], count);
        end
        tests++;
        if (out_contact !== exp_contact(8'd3, 32'h3C6F0000)) begin
            fails++;
            $display("FAIL hit_record: got %h want %h", out_contact,
                     exp_contact(8'd3, 32'h3C6F0000));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL hit_pop: valid=%b count=%0d, want 0/0", out_valid, count);
        end
    endtask

    task automatic test_miss();
        do_reset();
        hit(8'd9, 32'd0, 32'h1);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL miss: valid=%b count=%0d, want 0/0", out_valid, count);
        end
`ifdef CONTACT_STATS_EN
        tests++;
        if (tested_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            fails++;
            $display("FAIL miss_stats: tested=%0d hit=%0d, want 1/0", tested_cnt, hit_cnt);
        end
`endif
    endtask

    task automatic test_hold();
        do_reset();
        @(negedge clk);
        done    = 1'b1;
        ret     = 32'd1;
        pair_id = 8'd5;
        repeat (50) @(negedge clk);
        done = 1'b0;
        ret  = '0;
        @(negedge clk);
        tests++;
        if (count !== 4'd1 || out_id !== 8'd5) begin
            fails++;
            $display("FAIL hold: count=%0d id=%0d, want 1/5", count, out_id);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) hit(8'(i), 32'd1, word(8'(i), 6));
        @(negedge clk);
        tests++;
        if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow: full=%b count=%0d ovf=%b, want 1/8/1", full, count, overflow);
        end
`ifdef CONTACT_STATS_EN
        tests++;
        if (drop_cnt !== 16'd1 || hit_cnt !== 32'd9) begin
            fails++;
            $display("FAIL overflow_stats: drop=%0d hit=%0d, want 1/9", drop_cnt, hit_cnt);
        end
`endif
        drain(0, 8);
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: ovf=%b, want 1", overflow);
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < 8; i++) hit(8'(i), 32'd1, word(8'(i), 6));
        @(negedge clk);
        done      = 1'b1;
        ret       = 32'd1;
        pair_id   = 8'd8;
        cx        = word(8'd8, 0);
        cy        = word(8'd8, 1);
        cz        = word(8'd8, 2);
        normalx   = word(8'd8, 3);
        normaly   = word(8'd8, 4);
        normalz   = word(8'd8, 5);
        depth     = word(8'd8, 6);
        out_ready = 1'b1;
        @(negedge clk);
        done      = 1'b0;
        ret       = '0;
        out_ready = 1'b0;
        tests++;
        if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
            fails++;
            $display("FAIL push_pop_full: count=%0d ovf=%b full=%b, want 8/0/1",
                     count, overflow, full);
        end
        drain(1, 8);
    endtask

    task automatic test_back_to_back();
        int          exp_id = 0;
        bit          stalled = 1'b0;
        logic [7:0]  snap_id;
        logic [223:0] snap_c;
        do_reset();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    int guard = 0;
                    while (full && guard < 200) begin
                        @(negedge clk);
                        guard++;
                    end
                    hit(8'(i), 32'd1, word(8'(i), 6));
                end
            end
            begin
                for (int cyc = 0; cyc < 1000 && exp_id < 20; cyc++) begin
                    logic rdy;
                    @(negedge clk);
                    if (stalled) begin
                        tests++;
                        if (out_valid !== 1'b1 || out_id !== snap_id || out_contact !== snap_c) begin
                            fails++;
                            $display("FAIL stall_hold: valid=%b id=%0d, want 1/%0d",
                                     out_valid, out_id, snap_id);
                        end
                    end
                    rdy       = 1'($urandom_range(0, 1));
                    out_ready = rdy;
                    if (out_valid && rdy) begin
                        tests++;
                        if (out_id !== 8'(exp_id) ||
                            out_contact !== exp_contact(8'(exp_id), word(8'(exp_id), 6))) begin
                            fails++;
                            $display("FAIL order: id=%0d, want %0d", out_id, exp_id);
                        end
                        exp_id++;
                    end
                    stalled = out_valid && !rdy;
                    snap_id = out_id;
                    snap_c  = out_contact;
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        tests++;
        if (exp_id != 20 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_total: popped=%0d ovf=%b, want 20/0", exp_id, overflow);
        end

        for (int i = 0; i < 4; i++) hit(8'(i), 32'd1, word(8'(i), 6));
        tests++;
        if (count !== 4'd4) begin
            fails++;
            $display("FAIL pre_rst_count: count=%0d, want 4", count);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst: valid=%b count=%0d ovf=%b, want 0/0/0",
                     out_valid, count, overflow);
        end
    endtask

    initial begin
        rst       = 1'b1;
        done      = 1'b0;
        ret       = '0;
        pair_id   = '0;
        cx        = '0;
        cy        = '0;
        cz        = '0;
        normalx   = '0;
        normaly   = '0;
        normalz   = '0;
        depth     = '0;
        out_ready = 1'b0;
        test_reset();
        test_hit();
        test_miss();
        test_hold();
        test_overflow();
        test_push_pop_full();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
